// File: rtl/gauss_moment_acc_pkg.sv
// gauss_pkg: shared constants, sample type and FSM state encoding for the
// Gaussian moment accumulator slice.
//   DW           default sample width
//   LOG2_N_DFLT  default log2 of samples per block
//   WARMUP_DFLT  default number of discarded warm-up samples
//   sample_t     signed sample type
//   acc_state_e  measurement FSM states
package gauss_pkg;

    localparam int unsigned DW          = 16;
    localparam int unsigned LOG2_N_DFLT = 8;
    localparam int unsigned WARMUP_DFLT = 8;

    typedef logic signed [DW-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        ACCUM,
        DONE
    } acc_state_e;

endpackage

// File: rtl/gauss_moment_acc_if.sv
// gauss_moment_acc_if: command, sample and result signals of the moment
// accumulator.
//   master: drives start/in_valid/in_16, observes status and results
//   slave : the accumulator side
//   start, in_valid, in_16 : command and sample input
//   busy, done             : status
//   sum_out, sumsq_out, mean_out, min_out, max_out : block results
interface gauss_moment_acc_if #(
    parameter int unsigned DW     = 16,
    parameter int unsigned LOG2_N = 8
);
    logic                         start;
    logic                         in_valid;
    logic signed [DW-1:0]         in_16;
    logic                         busy;
    logic                         done;
    logic signed [DW+LOG2_N-1:0]  sum_out;
    logic [2*DW+LOG2_N-1:0]       sumsq_out;
    logic signed [DW-1:0]         mean_out;
    logic signed [DW-1:0]         min_out;
    logic signed [DW-1:0]         max_out;

    modport master (
        output start, in_valid, in_16,
        input  busy, done, sum_out, sumsq_out, mean_out, min_out, max_out
    );

    modport slave (
        input  start, in_valid, in_16,
        output busy, done, sum_out, sumsq_out, mean_out, min_out, max_out
    );
endinterface

// File: rtl/gauss_moment_acc_moment_mac.sv
// moment_mac: sum and sum-of-squares accumulators.
//   clk, reset : clock, synchronous active-high reset
//   clr        : zero both accumulators (wins over en)
//   en         : accumulate sample this cycle
//   sample     : signed input sample
//   sum_nxt    : next-state sum (includes this cycle's sample when en)
//   sumsq_nxt  : next-state sum of squares
// Next-state values are exported so the owner can capture the final block
// result on the same edge that accepts the last sample.
module moment_mac #(
    parameter int unsigned DW     = 16,
    parameter int unsigned LOG2_N = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clr,
    input  logic                        en,
    input  logic signed [DW-1:0]        sample,
    output logic signed [DW+LOG2_N-1:0] sum_nxt,
    output logic [2*DW+LOG2_N-1:0]      sumsq_nxt
);
    localparam int unsigned SW = DW + LOG2_N;
    localparam int unsigned QW = 2 * DW + LOG2_N;

    logic signed [SW-1:0]   sum_q, sum_d;
    logic [QW-1:0]          sumsq_q, sumsq_d;
    logic signed [2*DW-1:0] sq;

    always_comb begin
        // Full 2*DW signed product; (-2^(DW-1))^2 still fits as a positive value.
        sq      = sample * sample;
        sum_d   = sum_q;
        sumsq_d = sumsq_q;
        if (clr) begin
            sum_d   = '0;
            sumsq_d = '0;
        end else if (en) begin
            sum_d   = sum_q + SW'(sample);
            sumsq_d = sumsq_q + QW'($unsigned(sq));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q   <= '0;
            sumsq_q <= '0;
        end else begin
            sum_q   <= sum_d;
            sumsq_q <= sumsq_d;
        end
    end

    assign sum_nxt   = sum_d;
    assign sumsq_nxt = sumsq_d;

endmodule

// File: rtl/gauss_moment_acc.sv
// gauss_moment_acc: captures a block of 2^LOG2_N signed samples after
// discarding WARMUP valid samples, and reports sum, sum of squares and mean.
//   clk, reset : clock, synchronous active-high reset
//   bus        : gauss_moment_acc_if slave (start/in_valid/in_16 in;
//                busy/done/sum_out/sumsq_out/mean_out/min_out/max_out out)
// Optional: define GAUSS_MOMENT_MINMAX_EN to track block min/max; otherwise
// min_out/max_out are tied to 0.
module gauss_moment_acc #(
    parameter int unsigned DW     = gauss_pkg::DW,
    parameter int unsigned LOG2_N = gauss_pkg::LOG2_N_DFLT,
    parameter int unsigned WARMUP = gauss_pkg::WARMUP_DFLT
) (
    input  logic                clk,
    input  logic                reset,
    gauss_moment_acc_if.slave   bus
);
    import gauss_pkg::*;

    localparam int unsigned CW = LOG2_N + 1;
    localparam int unsigned SW = DW + LOG2_N;
    localparam int unsigned QW = 2 * DW + LOG2_N;
    localparam int unsigned WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam logic [CW-1:0] LAST  = CW'(2 ** LOG2_N - 1);
    localparam logic [WW-1:0] WLAST = WW'((WARMUP == 0) ? 0 : WARMUP - 1);

    acc_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WW-1:0]     wcnt_q, wcnt_d;
    logic              mac_clr, mac_en, load;

    logic signed [SW-1:0] sum_nxt, sum_res_q, sum_res_d;
    logic [QW-1:0]        sumsq_nxt, sumsq_res_q, sumsq_res_d;
    logic signed [DW-1:0] mean_res_q, mean_res_d;

    moment_mac #(
        .DW     (DW),
        .LOG2_N (LOG2_N)
    ) u_mac (
        .clk       (clk),
        .reset     (reset),
        .clr       (mac_clr),
        .en        (mac_en),
        .sample    (bus.in_16),
        .sum_nxt   (sum_nxt),
        .sumsq_nxt (sumsq_nxt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        mac_clr = 1'b0;
        mac_en  = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mac_clr = 1'b1;
                    cnt_d   = '0;
                    wcnt_d  = '0;
                    state_d = (WARMUP == 0) ? ACCUM : gauss_pkg::WARMUP;
                end
            end
            gauss_pkg::WARMUP: begin
                if (bus.in_valid) begin
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == WLAST) state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (bus.in_valid) begin
                    mac_en = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                        load    = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Results capture the accumulators' next state so they are valid
        // in the very cycle done is high.
        sum_res_d   = load ? sum_nxt : sum_res_q;
        sumsq_res_d = load ? sumsq_nxt : sumsq_res_q;
        mean_res_d  = load ? DW'(sum_nxt >>> LOG2_N) : mean_res_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wcnt_q      <= '0;
            sum_res_q   <= '0;
            sumsq_res_q <= '0;
            mean_res_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wcnt_q      <= wcnt_d;
            sum_res_q   <= sum_res_d;
            sumsq_res_q <= sumsq_res_d;
            mean_res_q  <= mean_res_d;
        end
    end

    assign bus.busy      = (state_q == gauss_pkg::WARMUP) || (state_q == ACCUM);
    assign bus.done      = (state_q == DONE);
    assign bus.sum_out   = sum_res_q;
    assign bus.sumsq_out = sumsq_res_q;
    assign bus.mean_out  = mean_res_q;

`ifdef GAUSS_MOMENT_MINMAX_EN
    logic signed [DW-1:0] min_q, min_d, max_q, max_d;
    logic signed [DW-1:0] min_res_q, min_res_d, max_res_q, max_res_d;

    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (mac_en) begin
            // First accumulated sample seeds both trackers.
            if (cnt_q == '0) begin
                min_d = bus.in_16;
                max_d = bus.in_16;
            end else begin
                if (bus.in_16 < min_q) min_d = bus.in_16;
                if (bus.in_16 > max_q) max_d = bus.in_16;
            end
        end
        min_res_d = load ? min_d : min_res_q;
        max_res_d = load ? max_d : max_res_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            min_q     <= '0;
            max_q     <= '0;
            min_res_q <= '0;
            max_res_q <= '0;
        end else begin
            min_q     <= min_d;
            max_q     <= max_d;
            min_res_q <= min_res_d;
            max_res_q <= max_res_d;
        end
    end

    assign bus.min_out = min_res_q;
    assign bus.max_out = max_res_q;
`else
    assign bus.min_out = '0;
    assign bus.max_out = '0;
`endif

endmodule

// File: tb/tb_gauss_moment_acc.sv
// tb_gauss_moment_acc: three accumulator instances (LOG2_N=2/WARMUP=2,
// LOG2_N=2/WARMUP=0, defaults) driven by directed and random sample blocks
// and compared against block statistics computed directly from the samples.
module tb_gauss_moment_acc;
    import gauss_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]         st, vl, bsy, dn;
    logic [15:0]        dat   [3];
    logic signed [63:0] sum_o [3];
    logic signed [63:0] sq_o  [3];
    logic signed [63:0] mean_o[3];
    logic signed [63:0] min_o [3];
    logic signed [63:0] max_o [3];

    gauss_moment_acc_if #(.DW(16), .LOG2_N(2)) if0 ();
    gauss_moment_acc_if #(.DW(16), .LOG2_N(2)) if1 ();
    gauss_moment_acc_if #(.DW(16), .LOG2_N(8)) if2 ();

    gauss_moment_acc #(.DW(16), .LOG2_N(2), .WARMUP(2)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    gauss_moment_acc #(.DW(16), .LOG2_N(2), .WARMUP(0)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    gauss_moment_acc #(.DW(16), .LOG2_N(8), .WARMUP(8)) dut2 (.clk(clk), .reset(reset), .bus(if2));

    assign if0.start = st[0];  assign if0.in_valid = vl[0];  assign if0.in_16 = dat[0];
    assign if1.start = st[1];  assign if1.in_valid = vl[1];  assign if1.in_16 = dat[1];
    assign if2.start = st[2];  assign if2.in_valid = vl[2];  assign if2.in_16 = dat[2];
    assign bsy[0] = if0.busy;  assign dn[0] = if0.done;
    assign bsy[1] = if1.busy;  assign dn[1] = if1.done;
    assign bsy[2] = if2.busy;  assign dn[2] = if2.done;
    assign sum_o[0]  = 64'(if0.sum_out);   assign sum_o[1]  = 64'(if1.sum_out);   assign sum_o[2]  = 64'(if2.sum_out);
    assign sq_o[0]   = 64'(if0.sumsq_out); assign sq_o[1]   = 64'(if1.sumsq_out); assign sq_o[2]   = 64'(if2.sumsq_out);
    assign mean_o[0] = 64'(if0.mean_out);  assign mean_o[1] = 64'(if1.mean_out);  assign mean_o[2] = 64'(if2.mean_out);
    assign min_o[0]  = 64'(if0.min_out);   assign min_o[1]  = 64'(if1.min_out);   assign min_o[2]  = 64'(if2.min_out);
    assign max_o[0]  = 64'(if0.max_out);   assign max_o[1]  = 64'(if1.max_out);   assign max_o[2]  = 64'(if2.max_out);

    int total = 0;
    int bad   = 0;

    // Expected (currently held) results per instance.
    longint p_sum[3], p_sq[3], p_mean[3], p_min[3], p_max[3];

    sample_t stim[$];

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_results(input int k, input string tag);
        chk({tag, "_sum"},   sum_o[k],  p_sum[k]);
        chk({tag, "_sumsq"}, sq_o[k],   p_sq[k]);
        chk({tag, "_mean"},  mean_o[k], p_mean[k]);
        chk({tag, "_min"},   min_o[k],  p_min[k]);
        chk({tag, "_max"},   max_o[k],  p_max[k]);
    endtask

    task automatic clear_expect();
        for (int k = 0; k < 3; k++) begin
            p_sum[k] = 0; p_sq[k] = 0; p_mean[k] = 0; p_min[k] = 0; p_max[k] = 0;
        end
    endtask

    function automatic sample_t rnd_sample();
        int r;
        if ($urandom_range(0, 7) == 0)
            return ($urandom_range(0, 1) == 0) ? sample_t'(16'h8000) : sample_t'(16'h7FFF);
        r = int'($urandom_range(0, 16383)) + int'($urandom_range(0, 16383))
          + int'($urandom_range(0, 16383)) + int'($urandom_range(0, 16383)) - 32766;
        return sample_t'(r);
    endfunction

    // gap: 0 = valid every cycle, 1 = valid every other cycle, 2 = random.
    // start_valid drives in_valid together with start; restart pulses start mid-block.
    task automatic run_block(input int k, input int lg, input int w, input int gap,
                             input bit start_valid, input bit restart);
        int     n       = 1 << lg;
        int     total_s = w + n;
        int     idx     = 0;
        int     cyc     = 0;
        logic   v;
        longint es = 0, eq = 0, emn = 0, emx = 0;

        for (int i = w; i < total_s; i++) begin
            longint s = longint'(stim[i]);
            es += s;
            eq += s * s;
            if (i == w) begin emn = s; emx = s; end
            else begin
                if (s < emn) emn = s;
                if (s > emx) emx = s;
            end
        end

        chk("idle_before_start", 64'(bsy[k]), 64'd0);
        st[k] = 1'b1; vl[k] = start_valid; dat[k] = 16'h7FFF;
        tick();
        st[k] = 1'b0;
        chk("busy_after_start", 64'(bsy[k]), 64'd1);

        while (idx < total_s && cyc < 4 * total_s + 20) begin
            case (gap)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            vl[k]  = v;
            dat[k] = v ? 16'(stim[idx]) : 16'($urandom);
            if (restart && idx == total_s / 2) st[k] = 1'b1;
            tick();
            st[k] = 1'b0;
            cyc++;
            if (v) idx++;
            if (idx < total_s) begin
                chk("run_busy", 64'(bsy[k]), 64'd1);
                chk("run_done", 64'(dn[k]), 64'd0);
                chk("run_sum_held", sum_o[k], p_sum[k]);
            end
        end
        chk("sample_budget", 64'(idx), 64'(total_s));
        vl[k] = 1'b0;

        p_sum[k]  = es;
        p_sq[k]   = eq;
        p_mean[k] = es >>> lg;
`ifdef GAUSS_MOMENT_MINMAX_EN
        p_min[k]  = emn;
        p_max[k]  = emx;
`else
        p_min[k]  = 0;
        p_max[k]  = 0;
`endif
        chk("done_pulse", 64'(dn[k]), 64'd1);
        chk("done_busy", 64'(bsy[k]), 64'd0);
        chk_results(k, "done");
        tick();
        chk("after_done", 64'(dn[k]), 64'd0);
        chk("after_busy", 64'(bsy[k]), 64'd0);
        chk_results(k, "held");
    endtask

    initial begin
        st = '0; vl = '0;
        for (int k = 0; k < 3; k++) dat[k] = '0;
        clear_expect();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("reset_busy", 64'(bsy[k]), 64'd0);
            chk("reset_done", 64'(dn[k]), 64'd0);
            chk_results(k, "reset");
        end

        // Warm-up discards two full-scale samples, then four 0x0100.
        stim = {};
        stim.push_back(sample_t'(16'h7FFF)); stim.push_back(sample_t'(16'h7FFF));
        repeat (4) stim.push_back(sample_t'(16'h0100));
        run_block(0, 2, 2, 0, 1'b0, 1'b0);

        // No warm-up, negative samples, floor mean.
        stim = {};
        for (int i = 0; i < 4; i++) stim.push_back(sample_t'(-(i + 1)));
        run_block(1, 2, 0, 0, 1'b0, 1'b0);

        // Worst-case magnitude on every sample.
        stim = {};
        repeat (264) stim.push_back(sample_t'(16'h8000));
        run_block(2, 8, 8, 0, 1'b1, 1'b0);

        // Toggled in_valid, start with in_valid, second start mid-block.
        stim = {};
        repeat (6) stim.push_back(rnd_sample());
        run_block(0, 2, 2, 1, 1'b1, 1'b1);
        stim = {};
        repeat (264) stim.push_back(rnd_sample());
        run_block(2, 8, 8, 1, 1'b0, 1'b1);

        // Random blocks with random stalls.
        for (int r = 0; r < 4; r++) begin
            stim = {};
            repeat (6) stim.push_back(rnd_sample());
            run_block(0, 2, 2, 2, r[0], r[1]);
            stim = {};
            repeat (4) stim.push_back(rnd_sample());
            run_block(1, 2, 0, 2, r[1], r[0]);
        end
        stim = {};
        repeat (264) stim.push_back(rnd_sample());
        run_block(2, 8, 8, 2, 1'b1, 1'b0);

        // Reset in the middle of ACCUM, then a clean rerun of the same block.
        stim = {};
        repeat (6) stim.push_back(rnd_sample());
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vl[0] = 1'b1; dat[0] = 16'(stim[i]);
            tick();
        end
        vl[0] = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_expect();
        for (int k = 0; k < 3; k++) begin
            chk("midreset_busy", 64'(bsy[k]), 64'd0);
            chk("midreset_done", 64'(dn[k]), 64'd0);
            chk_results(k, "midreset");
        end
        run_block(0, 2, 2, 0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
